primary_ray_gen: RTL and testbench



---
 rtl/primary_ray_gen.sv | 188 ++++++++++++++++++
 tb/tb_primary_ray_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/primary_ray_gen.sv
// ============================================================================
// Module   : primary_ray_gen
// Purpose  : Walks every pixel of a frame and emits one primary ray per pixel.
//            Each direction is built incrementally with adders only.
//            Optional macro: PRIMARY_RAY_JITTER_EN adds LFSR sub-pixel jitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module primary_ray_gen #(
  parameter int FW = 32,
  parameter int XW = 10,
  parameter int YW = 10
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            frame_start,
  input  logic            rs_valid,
  input  logic [3*FW-1:0] cam_pos,
  input  logic [3*FW-1:0] cam_blc,
  input  logic [3*FW-1:0] cam_du,
  input  logic [3*FW-1:0] cam_dv,
  input  logic [XW-1:0]   vp_width,
  input  logic [YW-1:0]   vp_height,
  output logic            busy,
  output logic            ray_valid,
  input  logic            ray_ready,
  output logic [3*FW-1:0] ray_orig,
  output logic [3*FW-1:0] ray_dir,
  output logic [XW-1:0]   ray_px,
  output logic [YW-1:0]   ray_py,
  output logic            frame_done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT_RS = 3'd1;
  localparam logic [2:0] S_LATCH   = 3'd2;
  localparam logic [2:0] S_EMIT    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // Component-wise vector helpers; each lane wraps independently.
  function automatic logic [3*FW-1:0] vadd(input logic [3*FW-1:0] a, input logic [3*FW-1:0] b);
    logic [3*FW-1:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) r[i*FW +: FW] = a[i*FW +: FW] + b[i*FW +: FW];
    return r;
  endfunction

  function automatic logic [3*FW-1:0] vsub(input logic [3*FW-1:0] a, input logic [3*FW-1:0] b);
    logic [3*FW-1:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) r[i*FW +: FW] = a[i*FW +: FW] - b[i*FW +: FW];
    return r;
  endfunction

  logic [2:0]      r_state;
  logic            r_busy;
  logic            r_valid;
  logic            r_done;
  logic [3*FW-1:0] r_pos;
  logic [3*FW-1:0] r_du;
  logic [3*FW-1:0] r_dv;
  logic [3*FW-1:0] r_dir;
  logic [3*FW-1:0] r_row_dir;
  logic [XW-1:0]   r_w;
  logic [YW-1:0]   r_h;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;

  logic            w_accept;
  logic            w_last_x;
  logic            w_last_y;
  logic [3*FW-1:0] w_row_next;

  assign w_accept   = r_valid & ray_ready;
  assign w_last_x   = (r_x == r_w - XW'(1));
  assign w_last_y   = (r_y == r_h - YW'(1));
  assign w_row_next = vadd(r_row_dir, r_dv);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_pos     <= '0;
      r_du      <= '0;
      r_dv      <= '0;
      r_dir     <= '0;
      r_row_dir <= '0;
      r_w       <= '0;
      r_h       <= '0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_busy  <= 1'b1;
            r_state <= rs_valid ? S_LATCH : S_WAIT_RS;
          end
        end
        S_WAIT_RS: begin
          if (rs_valid) r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_pos     <= cam_pos;
          r_du      <= cam_du;
          r_dv      <= cam_dv;
          r_w       <= vp_width;
          r_h       <= vp_height;
          r_dir     <= vsub(cam_blc, cam_pos);
          r_row_dir <= vsub(cam_blc, cam_pos);
          r_x       <= '0;
          r_y       <= '0;
          if (vp_width == '0 || vp_height == '0) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_valid <= 1'b1;
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (w_accept) begin
            if (!w_last_x) begin
              r_x   <= r_x + XW'(1);
              r_dir <= vadd(r_dir, r_du);
            end else if (!w_last_y) begin
              r_x       <= '0;
              r_y       <= r_y + YW'(1);
              r_row_dir <= w_row_next;
              r_dir     <= w_row_next;
            end else begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // busy stays high through the frame_done cycle so a coincident frame_start is dropped
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign ray_valid  = r_valid;
  assign frame_done = r_done;
  assign ray_orig   = r_pos;
  assign ray_px     = r_x;
  assign ray_py     = r_y;

`ifdef PRIMARY_RAY_JITTER_EN
  function automatic logic [3*FW-1:0] vhalf(input logic [3*FW-1:0] a);
    logic [3*FW-1:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) r[i*FW +: FW] = $signed(a[i*FW +: FW]) >>> 1;
    return r;
  endfunction

  logic [15:0]     r_lfsr;
  logic [3*FW-1:0] w_jit_u;
  logic [3*FW-1:0] w_jit_v;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lfsr <= 16'hACE1;
    end else if (w_accept) begin
      r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign w_jit_u = r_lfsr[0] ? vhalf(r_du) : '0;
  assign w_jit_v = r_lfsr[1] ? vhalf(r_dv) : '0;
  assign ray_dir = vadd(vadd(r_dir, w_jit_u), w_jit_v);
`else
  assign ray_dir = r_dir;
`endif

endmodule

`default_nettype wire

// File: tb/tb_primary_ray_gen.sv
// ============================================================================
// Module   : tb_primary_ray_gen
// Purpose  : Directed self-checking bench for primary_ray_gen (default build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_primary_ray_gen;

  localparam int FW = 32;
  localparam int XW = 10;
  localparam int YW = 10;

  logic            clk = 1'b0;
  logic            resetn;
  logic            frame_start;
  logic            rs_valid;
  logic [3*FW-1:0] cam_pos;
  logic [3*FW-1:0] cam_blc;
  logic [3*FW-1:0] cam_du;
  logic [3*FW-1:0] cam_dv;
  logic [XW-1:0]   vp_width;
  logic [YW-1:0]   vp_height;
  logic            busy;
  logic            ray_valid;
  logic            ray_ready;
  logic [3*FW-1:0] ray_orig;
  logic [3*FW-1:0] ray_dir;
  logic [XW-1:0]   ray_px;
  logic [YW-1:0]   ray_py;
  logic            frame_done;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;

  primary_ray_gen #(.FW(FW), .XW(XW), .YW(YW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .frame_start(frame_start),
    .rs_valid   (rs_valid),
    .cam_pos    (cam_pos),
    .cam_blc    (cam_blc),
    .cam_du     (cam_du),
    .cam_dv     (cam_dv),
    .vp_width   (vp_width),
    .vp_height  (vp_height),
    .busy       (busy),
    .ray_valid  (ray_valid),
    .ray_ready  (ray_ready),
    .ray_orig   (ray_orig),
    .ray_dir    (ray_dir),
    .ray_px     (ray_px),
    .ray_py     (ray_py),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Inputs change just after the rising edge, so the falling edge sees the handshake that will complete
  always @(negedge clk) if (resetn && ray_valid && ray_ready) n_acc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [3*FW-1:0] v3(input int x, input int y, input int z);
    return {z[FW-1:0], y[FW-1:0], x[FW-1:0]};
  endfunction

  // Closed-form reference: BLC - Pos + x*dU + y*dV per component
  function automatic logic [3*FW-1:0] mdir(input int x, input int y);
    logic [3*FW-1:0] r;
    logic [FW-1:0]   c;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      c = cam_blc[i*FW +: FW] - cam_pos[i*FW +: FW]
        + FW'(x) * cam_du[i*FW +: FW] + FW'(y) * cam_dv[i*FW +: FW];
      r[i*FW +: FW] = c;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3*FW-1:0] obs, input logic [3*FW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ray(input int x, input int y, input logic [3*FW-1:0] pos);
    chk("ray_valid", 96'(ray_valid), 96'(1));
    chk("ray_px", 96'(ray_px), 96'(x));
    chk("ray_py", 96'(ray_py), 96'(y));
    chk("ray_dir", ray_dir, mdir(x, y));
    chk("ray_orig", ray_orig, pos);
  endtask

  // rs_delay: cycles in WAIT_RS before rs_valid rises (0 = already valid)
  // stall_at/stall_n: hold ray_ready low for stall_n cycles on ray index stall_at
  // rst_after: assert reset once this many rays have been accepted (-1 = never)
  // poke_done: pulse frame_start during the frame_done cycle
  task automatic run_frame(input int rs_delay, input int stall_at, input int stall_n,
                           input int rst_after, input bit poke_done);
    int w;
    int h;
    logic [3*FW-1:0] pos;
    w     = int'(vp_width);
    h     = int'(vp_height);
    pos   = cam_pos;
    n_acc = 0;
    rs_valid    = (rs_delay == 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("busy_start", 96'(busy), 96'(1));
    if (rs_delay > 0) begin
      repeat (rs_delay) tick();
      chk("wait_rs_no_ray", 96'(ray_valid), 96'(0));
      chk("wait_rs_busy", 96'(busy), 96'(1));
      rs_valid = 1'b1;
      tick();
    end
    chk("latch_no_ray", 96'(ray_valid), 96'(0));
    tick();
    if (w == 0 || h == 0) begin
      chk("empty_done", 96'(frame_done), 96'(1));
      chk("empty_no_ray", 96'(ray_valid), 96'(0));
      tick();
      chk("empty_idle", 96'(busy), 96'(0));
      return;
    end
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (rst_after >= 0 && (y * w + x) == rst_after) begin
          resetn = 1'b0;
          #1;
          chk("rst_valid", 96'(ray_valid), 96'(0));
          chk("rst_busy", 96'(busy), 96'(0));
          chk("rst_done", 96'(frame_done), 96'(0));
          chk("rst_dir", ray_dir, 96'(0));
          tick();
          resetn = 1'b1;
          tick();
          chk("rst_no_done", 96'(frame_done), 96'(0));
          return;
        end
        chk_ray(x, y, pos);
        if ((y * w + x) == stall_at) begin
          ray_ready = 1'b0;
          repeat (stall_n) begin
            tick();
            chk_ray(x, y, pos);
          end
          ray_ready = 1'b1;
        end
        tick();
      end
    end
    chk("frame_done", 96'(frame_done), 96'(1));
    chk("done_no_ray", 96'(ray_valid), 96'(0));
    chk("done_busy", 96'(busy), 96'(1));
    chk("accepts", 96'(n_acc), 96'(w * h));
    frame_start = poke_done;
    tick();
    frame_start = 1'b0;
    chk("done_pulse", 96'(frame_done), 96'(0));
    chk("idle_busy", 96'(busy), 96'(0));
    if (poke_done) begin
      tick();
      tick();
      chk("poke_ignored_busy", 96'(busy), 96'(0));
      chk("poke_ignored_ray", 96'(ray_valid), 96'(0));
    end
  endtask

  initial begin
    resetn      = 1'b0;
    frame_start = 1'b0;
    rs_valid    = 1'b0;
    ray_ready   = 1'b1;
    cam_pos     = v3(0, 0, 0);
    cam_blc     = v3(100, 200, 300);
    cam_du      = v3(1, 0, 0);
    cam_dv      = v3(0, 1, 0);
    vp_width    = XW'(3);
    vp_height   = YW'(2);
    tick();
    tick();
    chk("reset_busy", 96'(busy), 96'(0));
    chk("reset_valid", 96'(ray_valid), 96'(0));
    chk("reset_done", 96'(frame_done), 96'(0));
    chk("reset_dir", ray_dir, 96'(0));
    chk("reset_orig", ray_orig, 96'(0));
    chk("reset_pxpy", 96'({ray_px, ray_py}), 96'(0));
    resetn = 1'b1;
    tick();

    // basic 3x2 frame, with a frame_start landing on frame_done
    run_frame(0, -1, 0, -1, 1'b1);

    // origin subtraction, single pixel
    cam_pos   = v3(10, 20, 30);
    vp_width  = XW'(1);
    vp_height = YW'(1);
    run_frame(0, -1, 0, -1, 1'b0);

    // backpressure on the second ray
    cam_pos   = v3(0, 0, 0);
    vp_width  = XW'(3);
    vp_height = YW'(2);
    run_frame(0, 1, 3, -1, 1'b0);

    // render state arrives 5 cycles late, negative steps for wrap coverage
    cam_du = v3(-3, 2, 0);
    cam_dv = v3(0, -5, 7);
    run_frame(5, -1, 0, -1, 1'b0);

    // zero-width viewport
    vp_width = XW'(0);
    run_frame(0, -1, 0, -1, 1'b0);

    // reset after the second accept, then a clean restart
    cam_du   = v3(1, 0, 0);
    cam_dv   = v3(0, 1, 0);
    cam_pos  = v3(7, 8, 9);
    vp_width = XW'(3);
    run_frame(0, -1, 0, 2, 1'b0);
    run_frame(0, -1, 0, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
